// File: rtl/duty_slew_ctrl.sv
// duty_slew_ctrl
//   Sits in front of the PWM generator. It turns a signed speed command into an
//   unsigned offset-binary duty word. The target is clamped to a safe window.
//   The duty moves toward the target by at most STEP per PWM period, and it
//   changes only when PWM_synch pulses. Soft stop ramps the duty back to MID
//   before the block idles. A fault forces MID at once and latches until a
//   clear arrives while the fault input is low.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   en         drive enable (level)
//   spd        signed speed command, two's complement
//   spd_vld    one-cycle strobe that captures spd into the target
//   PWM_synch  one-cycle pulse per PWM period; the only point where duty slews
//   fault      overcurrent/fault indication (level)
//   fault_clr  one-cycle strobe that clears a latched fault
//   duty       registered duty word to the PWM
//   at_target  registered: running and duty equals target
//   faulted    registered: fault state is latched
module duty_slew_ctrl #(
  parameter int                  DATA_W   = 11,
  parameter logic [DATA_W-1:0]   MID      = 11'd1024,
  parameter logic [DATA_W-1:0]   DUTY_MIN = 11'd48,
  parameter logic [DATA_W-1:0]   DUTY_MAX = 11'd2000,
  parameter logic [DATA_W-1:0]   STEP     = 11'd16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] spd,
  input  logic              spd_vld,
  input  logic              PWM_synch,
  input  logic              fault,
  input  logic              fault_clr,
  output logic [DATA_W-1:0] duty,
  output logic              at_target,
  output logic              faulted
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_RUN   = 2'd1,
    S_STOP  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t            state_p0;
  state_t            next_state;
  logic [DATA_W-1:0] target_p0;
  logic [DATA_W-1:0] next_target;
  logic [DATA_W-1:0] next_duty;
  logic signed [DATA_W:0] sum_p0;

  // Clamp a 12-bit signed offset-binary value into the legal duty window.
  function automatic logic [DATA_W-1:0] clamp_duty(input logic signed [DATA_W:0] v);
    logic [DATA_W-1:0] r;
    if (v < $signed({1'b0, DUTY_MIN}))
      r = DUTY_MIN;
    else if (v > $signed({1'b0, DUTY_MAX}))
      r = DUTY_MAX;
    else
      r = v[DATA_W-1:0];
    return r;
  endfunction

  // One slew step from cur toward tgt, limited to STEP in magnitude. Both
  // operands are in the clamped window, so cur +/- STEP cannot wrap.
  function automatic logic [DATA_W-1:0] step_toward(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] tgt);
    logic signed [DATA_W:0] diff;
    logic [DATA_W-1:0]      r;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > $signed({1'b0, STEP}))
      r = cur + STEP;
    else if (diff < -$signed({1'b0, STEP}))
      r = cur - STEP;
    else
      r = tgt;
    return r;
  endfunction

  // Stage p0: offset-binary conversion of the incoming command
  assign sum_p0 = $signed({spd[DATA_W-1], spd}) + $signed({1'b0, MID});

  always_comb begin
    next_state  = state_p0;
    next_duty   = duty;
    next_target = spd_vld ? clamp_duty(sum_p0) : target_p0;

    if (fault) begin
      // Fault wins over everything and skips the slew limiter.
      next_state = S_FAULT;
      next_duty  = MID;
    end else begin
      case (state_p0)
        S_OFF: begin
          next_duty = MID;
          if (en) next_state = S_RUN;
        end
        S_RUN: begin
          // Slew uses the target held before this edge; a same-cycle
          // spd_vld only lands on the following synch.
          if (PWM_synch) next_duty = step_toward(duty, target_p0);
          if (!en) next_state = S_STOP;
        end
        S_STOP: begin
          if (PWM_synch) next_duty = step_toward(duty, MID);
          if (en)
            next_state = S_RUN;
          else if (next_duty == MID)
            next_state = S_OFF;
        end
        S_FAULT: begin
          next_duty = MID;
          if (fault_clr) next_state = S_OFF;
        end
        default: begin
          next_state = S_OFF;
          next_duty  = MID;
        end
      endcase
    end
  end

  // Stage p1: registered state, target and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= S_OFF;
      target_p0 <= MID;
      duty      <= MID;
      at_target <= 1'b0;
      faulted   <= 1'b0;
    end else begin
      state_p0  <= next_state;
      target_p0 <= next_target;
      duty      <= next_duty;
      at_target <= (next_state == S_RUN) && (next_duty == next_target);
      faulted   <= (next_state == S_FAULT);
    end
  end

endmodule

// File: tb/tb_duty_slew_ctrl.sv
// Directed bench for duty_slew_ctrl: a vector table for the ramp, stop and
// same-cycle cases, hand sequences for fault latching and reset mid-ramp, and
// a monitor that duty stays put unless synch, fault or rst was present.
module tb_duty_slew_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [10:0] spd = 11'd0;
  logic        spd_vld = 1'b0;
  logic        PWM_synch = 1'b0;
  logic        fault = 1'b0;
  logic        fault_clr = 1'b0;
  logic [10:0] duty;
  logic        at_target;
  logic        faulted;

  int checks = 0;
  int errors = 0;

  duty_slew_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .spd       (spd),
    .spd_vld   (spd_vld),
    .PWM_synch (PWM_synch),
    .fault     (fault),
    .fault_clr (fault_clr),
    .duty      (duty),
    .at_target (at_target),
    .faulted   (faulted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [10:0] spd;
    logic        vld;
    logic        syn;
    logic        flt;
    logic        clr;
    logic        r;
    logic [10:0] e_duty;
    logic        e_at;
    logic        e_flt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en_i, input int s, input logic vld_i,
                              input logic syn_i, input logic flt_i, input logic clr_i,
                              input logic r_i, input int d, input logic a, input logic f);
    vec_t v;
    v.en = en_i; v.spd = 11'(s); v.vld = vld_i; v.syn = syn_i;
    v.flt = flt_i; v.clr = clr_i; v.r = r_i;
    v.e_duty = 11'(d); v.e_at = a; v.e_flt = f;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    en = v.en; spd = v.spd; spd_vld = v.vld; PWM_synch = v.syn;
    fault = v.flt; fault_clr = v.clr; rst = v.r;
    @(posedge clk);
    #1;
    checks++;
    if (duty !== v.e_duty) begin
      errors++;
      $display("FAIL %s duty got %0d want %0d", nm, duty, v.e_duty);
    end
    checks++;
    if (at_target !== v.e_at) begin
      errors++;
      $display("FAIL %s at_target got %0b want %0b", nm, at_target, v.e_at);
    end
    checks++;
    if (faulted !== v.e_flt) begin
      errors++;
      $display("FAIL %s faulted got %0b want %0b", nm, faulted, v.e_flt);
    end
  endtask

  // Duty may only move on an edge that saw synch, fault or rst.
  logic        allow_q = 1'b1;
  logic        have_prev = 1'b0;
  logic [10:0] prev_duty = 11'd0;

  always @(posedge clk) allow_q <= PWM_synch | fault | rst;

  always @(negedge clk) begin
    if (have_prev && !allow_q) begin
      checks++;
      if (duty !== prev_duty) begin
        errors++;
        $display("FAIL static_duty at %0t got %0d want %0d", $time, duty, prev_duty);
      end
    end
    prev_duty <= duty;
    have_prev <= 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then +200 ramp: 13 synchs end at 1224, idles between synchs.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1024, 0, 0));
    tbl.push_back(mk(1, 200, 1, 0, 0, 0, 0, 1024, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1024, 0, 0));
    for (int k = 1; k <= 13; k++) begin
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, (k < 13) ? 1024 + 16 * k : 1224, k == 13, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, (k < 13) ? 1024 + 16 * k : 1224, k == 13, 0));
    end
    // Soft stop from 1224: 13 synchs down to MID, then OFF holds MID.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1224, 0, 0));
    for (int k = 1; k <= 13; k++)
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, (k < 13) ? 1224 - 16 * k : 1024, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1024, 0, 0));
    // Back to RUN toward 1224, climb to 1200.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1024, 0, 0));
    for (int k = 1; k <= 11; k++)
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1024 + 16 * k, 0, 0));
    // spd_vld with synch: old target 1224 applies on this synch.
    tbl.push_back(mk(1, 76, 1, 1, 0, 0, 0, 1216, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1216, 0, 0));
    for (int k = 1; k <= 6; k++)
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1216 - 16 * k, 0, 0));
    // STOP at 1120 heads to MID despite target 1224; re-enable has no jump.
    tbl.push_back(mk(0, 200, 1, 0, 0, 0, 0, 1120, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1104, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1104, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1120, 0, 0));
    // Full-scale negative command clamps to 48, then positive to 2000.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1024, 0, 0));
    tbl.push_back(mk(1, -1024, 1, 0, 0, 0, 0, 1024, 0, 0));
    for (int k = 1; k <= 61; k++)
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1024 - 16 * k, k == 61, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 48, 1, 0));
    tbl.push_back(mk(1, 1023, 1, 0, 0, 0, 0, 48, 0, 0));
    for (int k = 1; k <= 122; k++)
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 48 + 16 * k, k == 122, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2000, 1, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec[%0d]", i));

    // Ramp down to 1500: last step is a partial 4.
    apply(mk(1, 476, 1, 0, 0, 0, 0, 2000, 0, 0), "tgt1500");
    for (int k = 1; k <= 32; k++)
      apply(mk(1, 0, 0, 1, 0, 0, 0, (k < 32) ? 2000 - 16 * k : 1500, k == 32, 0),
            $sformatf("down1500[%0d]", k));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 1500, 1, 0), "hold1500");

    // Fault mid-period: immediate MID, clear ignored while fault high, en ignored.
    apply(mk(1, 0, 0, 0, 1, 0, 0, 1024, 0, 1), "fault_entry");
    apply(mk(1, 0, 0, 0, 1, 1, 0, 1024, 0, 1), "clr_while_fault");
    apply(mk(1, 0, 0, 1, 1, 0, 0, 1024, 0, 1), "fault_synch");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 1024, 0, 1), "fault_latched");
    apply(mk(1, 0, 0, 1, 0, 0, 0, 1024, 0, 1), "fault_en_synch");
    apply(mk(1, 0, 0, 0, 0, 1, 0, 1024, 0, 0), "fault_cleared");

    // Ramp to 1600 then reset mid-run.
    apply(mk(1, 576, 1, 0, 0, 0, 0, 1024, 0, 0), "tgt1600");
    for (int k = 1; k <= 36; k++)
      apply(mk(1, 0, 0, 1, 0, 0, 0, 1024 + 16 * k, k == 36, 0), $sformatf("up1600[%0d]", k));
    apply(mk(1, 0, 0, 0, 0, 0, 1, 1024, 0, 0), "rst_mid_run");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1024, 0, 0), "after_rst");
    apply(mk(0, 0, 0, 1, 0, 0, 0, 1024, 0, 0), "off_synch");

    // Reset discards a latched fault.
    apply(mk(0, 0, 0, 0, 1, 0, 0, 1024, 0, 1), "fault_again");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1024, 0, 0), "rst_in_fault");
    apply(mk(0, 0, 0, 1, 0, 0, 0, 1024, 0, 0), "off_after_rst");

    en = 1'b0; spd_vld = 1'b0; PWM_synch = 1'b0; fault = 1'b0; fault_clr = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
